gcd_host: RTL

Initiator-side sequencer for the subtractive GCD core. It accepts an operand pair over a valid/ready request channel and serializes the pair onto the core's shared `data_in` bus: A on the start cycle, B on the next. It then waits for `done`, captures the result, and returns it on a valid/ready response channel. Zero operands are answered locally, because the subtractive core never terminates on them, and a watchdog bounds the wait for `done`. It sits between the system bus and one GCD datapath/controller pair.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_watchdog.sv | 41 ++++
 rtl/gcd_host.sv | 118 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD block family: default sizes and the host
// sequencer state encoding.
package gcd_pkg;

    localparam int GCD_WIDTH   = 16;
    localparam int GCD_TIMEOUT = 1023;

    typedef logic [2:0] gcd_host_state_t;

    localparam gcd_host_state_t ST_IDLE   = 3'd0;
    localparam gcd_host_state_t ST_LOAD_A = 3'd1;
    localparam gcd_host_state_t ST_LOAD_B = 3'd2;
    localparam gcd_host_state_t ST_WAIT   = 3'd3;
    localparam gcd_host_state_t ST_RESP   = 3'd4;

endpackage

// File: rtl/gcd_watchdog.sv
// Saturating cycle counter with synchronous clear; expired flags the last
// permitted cycle of a wait of TIMEOUT cycles.
module gcd_watchdog
    import gcd_pkg::*;
#(
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CW'(TIMEOUT))) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_host.sv
// Request/response sequencer in front of one subtractive GCD core: loads A then
// B over the shared data bus, waits for done under a watchdog, returns the result.
module gcd_host
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_y
);

    gcd_host_state_t  state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             err_q, err_d;
    logic             wd_expired;

    gcd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ST_LOAD_B),
        .enable  (state_q == ST_WAIT),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d = req_a;
                    b_d = req_b;
                    // The core never converges on a zero operand, so answer here.
                    if ((req_a == '0) || (req_b == '0)) begin
                        gcd_d   = req_a | req_b;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: state_d = ST_WAIT;
            ST_WAIT: begin
                if (gcd_done) begin
                    gcd_d   = gcd_y;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wd_expired) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: operand and result registers are reset too, so an aborted job leaves no stale value on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from registered state only; no path from req_* or rsp_ready.
    always_comb begin
        gcd_data = '0;
        case (state_q)
            ST_LOAD_A:        gcd_data = a_q;
            ST_LOAD_B, ST_WAIT: gcd_data = b_q;
            default:          gcd_data = '0;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign gcd_start = (state_q == ST_LOAD_A);
    assign rsp_gcd   = gcd_q;
    assign rsp_err   = err_q;

endmodule
